ft60x_bus_ctrl: RTL and testbench
=================================

FT60X_BUS_CTRL -- requirements
Module: ft60x_bus_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, FT60x bus width; legal values 16 (FT600) and 32 (FT601); BE_W = DATA_W/8.
REQ-002 SHALL have parameter MAX_BURST, default 256, maximum words per bus burst; legal range 1..1024.
REQ-003 SHALL have parameter ARB_MODE, default 0: 0 = fixed RX-first, 1 = round-robin between RX and TX.
REQ-004 SHALL have ports: iCLK in 1, the FT60x bus clock; reset in 1, asynchronous, active-high.
REQ-005 SHALL have ports iTXE_N in 1 (FT60x can accept a word) and iRXF_N in 1 (FT60x has a word); both active low.
REQ-006 SHALL have ports oOE_N, oRD_N, oWR_N out 1 each, FT60x strobes, active low.
REQ-007 SHALL have ports iDATA in DATA_W, oDATA out DATA_W, oBE out BE_W, oDATA_OE out 1 (tristate enable for the ioDATA/ioBE pads at top level).
REQ-008 SHALL have ports iBE in BE_W (byte enables returned by the FT60x on reads).
REQ-009 SHALL have TX source ports (show-ahead FIFO): tx_data in DATA_W, tx_be in BE_W, tx_empty in 1, tx_rd out 1.
REQ-010 SHALL have RX sink ports: rx_data out DATA_W, rx_be out BE_W, rx_full in 1, rx_wr out 1.
REQ-011 SHALL have status ports oBUSY out 1 (state != S_IDLE), tx_words out 32, rx_words out 32.

Function
REQ-012 SHALL sample and update all state on posedge iCLK only; states are S_IDLE, S_WR, S_WR_END, S_RD_OE, S_RD, S_RD_END.
REQ-013 S_IDLE SHALL evaluate rx_req = !iRXF_N & !rx_full and tx_req = !iTXE_N & !tx_empty.
REQ-014 Arbitration SHALL follow ARB_MODE: in mode 0, rx_req wins when both requests are set; in mode 1, the requester not granted last wins, and the last-grant bit resets to TX so RX wins the first tie.
REQ-015 On a TX grant, the block SHALL go to S_WR and clear burst_cnt.
REQ-016 On an RX grant, the block SHALL go to S_RD_OE and clear burst_cnt.
REQ-017 With neither request set, the block SHALL remain in S_IDLE.
REQ-018 In S_WR: oDATA_OE=1; oDATA=tx_data, oBE=tx_be; oWR_N=0 while tx_empty=0.
REQ-019 In S_WR, a write transfer SHALL occur on each edge with !oWR_N & !iTXE_N; tx_rd SHALL be 1 in exactly that cycle, and burst_cnt and tx_words SHALL increment.
REQ-020 S_WR SHALL move to S_WR_END when iTXE_N=1, when tx_empty=1, or on the transfer that makes burst_cnt reach MAX_BURST.
REQ-021 In S_WR, a word presented while iTXE_N=1 SHALL NOT be popped.
REQ-022 S_WR_END SHALL last 1 cycle with oWR_N=1 and oDATA_OE=0, then go to S_IDLE.
REQ-023 S_RD_OE SHALL last 1 cycle: oOE_N=0, oRD_N=1, oDATA_OE=0 (bus turnaround); then go to S_RD.
REQ-024 In S_RD: oOE_N=0 and oRD_N=0.
REQ-025 In S_RD, a read transfer SHALL occur on each edge with !iRXF_N & !rx_full; rx_wr SHALL be 1 that cycle, rx_data=iDATA, rx_be=iBE, and burst_cnt and rx_words SHALL increment.
REQ-026 S_RD SHALL move to S_RD_END when iRXF_N=1, when rx_full=1, or when burst_cnt reaches MAX_BURST.
REQ-027 In S_RD, rx_wr SHALL be 0 in any cycle where rx_full=1.
REQ-028 S_RD_END SHALL last 1 cycle with oOE_N=1, oRD_N=1, then go to S_IDLE.
REQ-029 oDATA_OE=1 and oOE_N=0 SHALL never be true in the same cycle.
REQ-030 oWR_N=0 and oRD_N=0 SHALL never be true in the same cycle.
REQ-031 burst_cnt SHALL be $clog2(MAX_BURST+1) bits wide; tx_words and rx_words SHALL wrap modulo 2^32 without saturation.
REQ-032 Outside S_WR, tx_rd SHALL be 0; outside S_RD, rx_wr SHALL be 0.

Reset
REQ-033 reset SHALL immediately, asynchronously, force: state=S_IDLE; oOE_N=oRD_N=oWR_N=1; oDATA_OE=0; tx_rd=rx_wr=0; burst_cnt, tx_words and rx_words = 0; last-grant bit = TX.
REQ-034 Reset asserted mid-burst SHALL abort the burst: no tx_rd or rx_wr pulse is issued after the reset edge, and operation resumes from S_IDLE once reset is released.

Verification
REQ-035 TX burst: DATA_W=32, tx FIFO holds 5 words, iTXE_N=0 -> 5 tx_rd pulses, oWR_N low for 5 cycles, tx_words=5, then S_WR_END -> S_IDLE.
REQ-036 TX backpressure: iTXE_N rises after word 2 of 4 -> exactly 2 pops, exit via S_WR_END; remaining 2 words go out in the next burst, and word 3 is not lost or duplicated.
REQ-037 RX burst: iRXF_N=0 for 3 words 0xA1,0xA2,0xA3 -> 1 S_RD_OE cycle with oDATA_OE=0, then 3 rx_wr pulses carrying 0xA1,0xA2,0xA3, rx_words=3.
REQ-038 Arbitration: both requests held continuously; ARB_MODE=0 -> RX bursts only; ARB_MODE=1 -> grants alternate RX, TX, RX.
REQ-039 Burst limit and reset: MAX_BURST=4 with 10 TX words pending -> bursts of 4, 4, 2; reset pulsed during the 2nd burst -> strobes high the same cycle, tx_words=0.

Source files
------------

// File: rtl/ft60x_bus_ctrl.sv
// rtl/ft60x_bus_ctrl.sv - FT600/FT601 synchronous FIFO bus master
// Moves words from a TX show-ahead FIFO to the FT60x and from the FT60x into an RX sink, in bounded bursts.
module ft60x_bus_ctrl #(
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 256,
  parameter int ARB_MODE  = 0,
  localparam int BE_W     = DATA_W / 8
) (
  input  logic              iCLK,
  input  logic              reset,
  input  logic              iTXE_N,
  input  logic              iRXF_N,
  output logic              oOE_N,
  output logic              oRD_N,
  output logic              oWR_N,
  input  logic [DATA_W-1:0] iDATA,
  output logic [DATA_W-1:0] oDATA,
  output logic [BE_W-1:0]   oBE,
  output logic              oDATA_OE,
  input  logic [BE_W-1:0]   iBE,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [BE_W-1:0]   tx_be,
  input  logic              tx_empty,
  output logic              tx_rd,
  output logic [DATA_W-1:0] rx_data,
  output logic [BE_W-1:0]   rx_be,
  input  logic              rx_full,
  output logic              rx_wr,
  output logic              oBUSY,
  output logic [31:0]       tx_words,
  output logic [31:0]       rx_words
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_WR_END, S_RD_OE, S_RD, S_RD_END
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] burst_cnt, burst_cnt_nxt;
  logic             last_rx, last_rx_nxt;
  logic             rx_req, tx_req;

  assign oDATA   = tx_data;
  assign oBE     = tx_be;
  assign rx_data = iDATA;
  assign rx_be   = iBE;
  assign oBUSY   = (state != S_IDLE);

  always_ff @(posedge iCLK or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      burst_cnt <= '0;
      last_rx   <= 1'b0;
      tx_words  <= '0;
      rx_words  <= '0;
    end else begin
      state     <= state_nxt;
      burst_cnt <= burst_cnt_nxt;
      last_rx   <= last_rx_nxt;
      if (tx_rd) tx_words <= tx_words + 32'd1;
      if (rx_wr) rx_words <= rx_words + 32'd1;
    end
  end

  always_comb begin
    state_nxt     = state;
    burst_cnt_nxt = burst_cnt;
    last_rx_nxt   = last_rx;
    oOE_N         = 1'b1;
    oRD_N         = 1'b1;
    oWR_N         = 1'b1;
    oDATA_OE      = 1'b0;
    tx_rd         = 1'b0;
    rx_wr         = 1'b0;
    rx_req        = !iRXF_N && !rx_full;
    tx_req        = !iTXE_N && !tx_empty;

    case (state)
      S_IDLE: begin
        // In round-robin mode RX yields a tie only when it held the last grant.
        if (rx_req && (!tx_req || (ARB_MODE == 0) || !last_rx)) begin
          state_nxt     = S_RD_OE;
          burst_cnt_nxt = '0;
          last_rx_nxt   = 1'b1;
        end else if (tx_req) begin
          state_nxt     = S_WR;
          burst_cnt_nxt = '0;
          last_rx_nxt   = 1'b0;
        end
      end
      S_WR: begin
        oDATA_OE = 1'b1;
        oWR_N    = tx_empty;
        tx_rd    = !tx_empty && !iTXE_N;
        if (tx_rd) burst_cnt_nxt = burst_cnt + CNT_W'(1);
        if (iTXE_N || tx_empty || (tx_rd && burst_cnt == CNT_LAST)) state_nxt = S_WR_END;
      end
      S_WR_END: state_nxt = S_IDLE;
      S_RD_OE: begin
        oOE_N     = 1'b0;
        state_nxt = S_RD;
      end
      S_RD: begin
        oOE_N = 1'b0;
        oRD_N = 1'b0;
        rx_wr = rx_req;
        if (rx_wr) burst_cnt_nxt = burst_cnt + CNT_W'(1);
        if (iRXF_N || rx_full || (rx_wr && burst_cnt == CNT_LAST)) state_nxt = S_RD_END;
      end
      S_RD_END: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ft60x_bus_ctrl.sv
// tb/tb_ft60x_bus_ctrl.sv - directed self-checking bench for ft60x_bus_ctrl
// Three instances: 0 = defaults, 1 = round-robin with burst 4, 2 = fixed priority with burst 4.
module tb_ft60x_bus_ctrl;
  localparam int DW = 32;
  localparam int BW = 4;

  logic iCLK = 1'b0;
  logic reset = 1'b0;
  always #5 iCLK = ~iCLK;

  logic [1:0] sel = 2'd0;
  logic txe_n = 1'b1;
  logic rx_full = 1'b0;

  logic [DW-1:0] mem [256];
  int wr_ptr = 0, rd_ptr = 0;
  logic [DW-1:0] rx_src [256];
  int rx_ptr = 0, rx_end = 0;

  wire tx_empty_w = (rd_ptr == wr_ptr);
  wire rxf_n_w = !(rx_ptr < rx_end);
  wire [DW-1:0] tx_data_w = mem[rd_ptr % 256];
  wire [DW-1:0] idata_w = rx_src[rx_ptr % 256];

  logic owr_n [3], ooe_n [3], ord_n [3], odoe [3], txrd [3], rxwr [3], busy [3];
  logic txempty_i [3], rxfn_i [3];
  logic [DW-1:0] odata [3], rxdata [3];
  logic [BW-1:0] obe [3], rxbe [3];
  logic [31:0] txw [3], rxw [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign txempty_i[g] = (sel == g) ? tx_empty_w : 1'b1;
    assign rxfn_i[g]    = (sel == g) ? rxf_n_w : 1'b1;
    ft60x_bus_ctrl #(
      .DATA_W(DW), .MAX_BURST((g == 0) ? 256 : 4), .ARB_MODE((g == 1) ? 1 : 0)
    ) dut (
      .iCLK(iCLK), .reset(reset), .iTXE_N(txe_n), .iRXF_N(rxfn_i[g]),
      .oOE_N(ooe_n[g]), .oRD_N(ord_n[g]), .oWR_N(owr_n[g]),
      .iDATA(idata_w), .oDATA(odata[g]), .oBE(obe[g]), .oDATA_OE(odoe[g]),
      .iBE(idata_w[7:4]), .tx_data(tx_data_w), .tx_be(tx_data_w[3:0]),
      .tx_empty(txempty_i[g]), .tx_rd(txrd[g]),
      .rx_data(rxdata[g]), .rx_be(rxbe[g]), .rx_full(rx_full), .rx_wr(rxwr[g]),
      .oBUSY(busy[g]), .tx_words(txw[g]), .rx_words(rxw[g])
    );
  end

  wire owr_s = owr_n[sel];
  wire ooe_s = ooe_n[sel];
  wire ord_s = ord_n[sel];
  wire odoe_s = odoe[sel];
  wire txrd_s = txrd[sel];
  wire rxwr_s = rxwr[sel];
  wire busy_s = busy[sel];
  wire [DW-1:0] odata_s = odata[sel];
  wire [DW-1:0] rxdata_s = rxdata[sel];

  int pop_cnt = 0, rxw_cnt = 0;
  logic [DW-1:0] pop_log [256];
  logic [DW-1:0] rx_log [256];

  // FIFO models: pop the TX source and advance the RX source on each DUT transfer.
  always @(posedge iCLK) begin
    if (txrd_s) begin
      pop_log[pop_cnt % 256] <= odata_s;
      pop_cnt <= pop_cnt + 1;
      rd_ptr  <= rd_ptr + 1;
    end
    if (rxwr_s) begin
      rx_log[rxw_cnt % 256] <= rxdata_s;
      rxw_cnt <= rxw_cnt + 1;
      rx_ptr  <= rx_ptr + 1;
    end
  end

  int wr_low = 0, rdoe_cnt = 0, rdoe_bad = 0, viol = 0, grant_cnt = 0, run = 0, nb = 0;
  logic grant_rx_log [64];
  int bursts [64];
  logic prev_odoe = 1'b0;

  always @(negedge iCLK) begin
    if (!owr_s) wr_low <= wr_low + 1;
    if (!ooe_s && ord_s) begin
      rdoe_cnt <= rdoe_cnt + 1;
      if (odoe_s) rdoe_bad <= rdoe_bad + 1;
      grant_rx_log[grant_cnt % 64] <= 1'b1;
      grant_cnt <= grant_cnt + 1;
    end else if (odoe_s && !prev_odoe) begin
      grant_rx_log[grant_cnt % 64] <= 1'b0;
      grant_cnt <= grant_cnt + 1;
    end
    prev_odoe <= odoe_s;
    if ((odoe_s && !ooe_s) || (!owr_s && !ord_s) || (rxwr_s && rx_full)) viol <= viol + 1;
    if (!owr_s) run <= run + 1;
    else if (run > 0) begin
      bursts[nb % 64] <= run;
      nb  <= nb + 1;
      run <= 0;
    end
  end

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge iCLK);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] w);
    mem[wr_ptr % 256] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  int b_pop, b_wl, b_g, b_rx, b_nb, tcount;

  initial begin
    #2 reset = 1'b1;
    #1;
    chk("rst_wr_n", owr_s, 1);
    chk("rst_oe_n", ooe_s, 1);
    chk("rst_rd_n", ord_s, 1);
    chk("rst_data_oe", odoe_s, 0);
    chk("rst_busy", busy_s, 0);
    chk("rst_tx_words", txw[0], 0);
    chk("rst_rx_words", rxw[0], 0);
    cyc(2);
    reset = 1'b0;
    cyc(1);

    // TX burst of 5 words
    b_pop = pop_cnt; b_wl = wr_low; b_g = grant_cnt;
    for (int k = 0; k < 5; k++) push(32'h11 + k);
    txe_n = 1'b0;
    cyc(10);
    chk("tx5_pops", pop_cnt - b_pop, 5);
    chk("tx5_wr_low", wr_low - b_wl, 5);
    chk("tx5_grants", grant_cnt - b_g, 1);
    for (int k = 0; k < 5; k++) chk($sformatf("tx5_word%0d", k), pop_log[b_pop + k], 32'h11 + k);
    chk("tx5_words", txw[0], 5);
    chk("tx5_idle", busy_s, 0);

    // TX backpressure after word 2 of 4
    b_pop = pop_cnt;
    for (int k = 0; k < 4; k++) push(32'h21 + k);
    for (int k = 0; k < 20 && (pop_cnt - b_pop) < 2; k++) cyc(1);
    txe_n = 1'b1;
    cyc(4);
    chk("bp_pops", pop_cnt - b_pop, 2);
    chk("bp_idle", busy_s, 0);
    chk("bp_words", txw[0], 7);
    txe_n = 1'b0;
    cyc(6);
    chk("bp_pops_all", pop_cnt - b_pop, 4);
    chk("bp_word3", pop_log[b_pop + 2], 32'h23);
    chk("bp_word4", pop_log[b_pop + 3], 32'h24);
    chk("bp_words_all", txw[0], 9);

    // RX: full sink blocks the grant, then a 3-word burst
    for (int k = 0; k < 3; k++) rx_src[(rx_ptr + k) % 256] = 32'hA1 + k;
    rx_full = 1'b1;
    rx_end = rx_ptr + 3;
    b_rx = rxw_cnt; b_g = rdoe_cnt;
    cyc(3);
    chk("rxfull_idle", busy_s, 0);
    chk("rxfull_nowr", rxw_cnt - b_rx, 0);
    rx_full = 1'b0;
    cyc(8);
    chk("rx3_oe_cycles", rdoe_cnt - b_g, 1);
    chk("rx3_wr", rxw_cnt - b_rx, 3);
    for (int k = 0; k < 3; k++) chk($sformatf("rx3_word%0d", k), rx_log[b_rx + k], 32'hA1 + k);
    chk("rx3_words", rxw[0], 3);
    chk("rx3_idle", busy_s, 0);

    // Burst limit 4 with 10 words pending
    sel = 2'd2;
    b_pop = pop_cnt; b_nb = nb;
    for (int k = 0; k < 10; k++) push(32'h31 + k);
    cyc(24);
    chk("lim_bursts", nb - b_nb, 3);
    chk("lim_b0", bursts[b_nb % 64], 4);
    chk("lim_b1", bursts[(b_nb + 1) % 64], 4);
    chk("lim_b2", bursts[(b_nb + 2) % 64], 2);
    chk("lim_pops", pop_cnt - b_pop, 10);
    chk("lim_words", txw[2], 10);

    // Fixed priority: RX always wins while both request
    b_pop = pop_cnt; b_g = grant_cnt;
    for (int k = 0; k < 40; k++) rx_src[(rx_ptr + k) % 256] = 32'h100 + k;
    for (int k = 0; k < 8; k++) push(32'h41 + k);
    rx_end = rx_ptr + 40;
    cyc(30);
    tcount = 0;
    for (int k = b_g; k < grant_cnt; k++) if (!grant_rx_log[k % 64]) tcount++;
    chk("arb0_many", ((grant_cnt - b_g) >= 3) ? 1 : 0, 1);
    chk("arb0_no_tx", tcount, 0);
    chk("arb0_no_pop", pop_cnt - b_pop, 0);
    rx_end = rx_ptr;
    cyc(20);
    chk("arb0_drain", pop_cnt - b_pop, 8);
    chk("arb0_words", txw[2], 18);

    // Round-robin: RX, TX, RX
    sel = 2'd1;
    b_pop = pop_cnt; b_g = grant_cnt;
    for (int k = 0; k < 40; k++) rx_src[(rx_ptr + k) % 256] = 32'h200 + k;
    for (int k = 0; k < 12; k++) push(32'h51 + k);
    rx_end = rx_ptr + 40;
    cyc(25);
    chk("arb1_g0", grant_rx_log[b_g % 64], 1);
    chk("arb1_g1", grant_rx_log[(b_g + 1) % 64], 0);
    chk("arb1_g2", grant_rx_log[(b_g + 2) % 64], 1);
    rx_end = rx_ptr;
    cyc(30);
    chk("arb1_drain", pop_cnt - b_pop, 12);
    chk("arb1_words", txw[1], 12);

    // Reset during the second burst of 4
    sel = 2'd2;
    b_pop = pop_cnt; b_nb = nb;
    for (int k = 0; k < 10; k++) push(32'h61 + k);
    for (int k = 0; k < 40 && !((nb - b_nb) == 1 && run == 2); k++) cyc(1);
    chk("rst_mid_reached", pop_cnt - b_pop, 5);
    reset = 1'b1;
    #1;
    chk("rstm_wr_n", owr_s, 1);
    chk("rstm_data_oe", odoe_s, 0);
    chk("rstm_tx_rd", txrd_s, 0);
    chk("rstm_words", txw[2], 0);
    chk("rstm_busy", busy_s, 0);
    cyc(2);
    chk("rstm_no_pop", pop_cnt - b_pop, 5);
    reset = 1'b0;
    cyc(16);
    chk("rstm_resume_pops", pop_cnt - b_pop, 10);
    chk("rstm_no_loss", pop_log[(b_pop + 5) % 256], 32'h66);
    chk("rstm_last", pop_log[(b_pop + 9) % 256], 32'h6A);
    chk("rstm_words_after", txw[2], 5);
    chk("rstm_idle", busy_s, 0);

    chk("excl_viol", viol, 0);
    chk("rdoe_data_oe", rdoe_bad, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
